// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped front end for the UART core.
// Holds the TX/RX byte FIFOs, the baud divisor and the overrun flag, and
// paces the core's write_enable/busy and read_ready/negate_read_ready
// handshakes one frame at a time.
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | no frame in flight; launch the FIFO head when the core is free
//   TX_START | uart_we issued, waiting for the core to raise busy
//   TX_SEND  | frame in flight, uart_data held until busy falls
//
// RX FSM
//   state    | meaning
//   RX_WAIT  | waiting for the core to present a received byte
//   RX_ACK   | byte taken, waiting for read_ready to drop
module uart_mmio_ctrl #(
  parameter int          TX_DEPTH   = 8,
  parameter int          RX_DEPTH   = 8,
  parameter logic [15:0] BAUD_RESET = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        irq,
  output logic        uart_we,
  output logic [7:0]  uart_data,
  output logic [15:0] uart_baud_max,
  output logic        uart_negate_rr,
  input  logic        uart_busy,
  input  logic        uart_read_ready,
  input  logic [7:0]  uart_rx_data
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_SEND} tx_state_t;
  typedef enum logic {RX_WAIT, RX_ACK} rx_state_t;

  tx_state_t tx_state, tx_state_n;
  rx_state_t rx_state, rx_state_n;

  logic [7:0]   tx_mem [TX_DEPTH];
  logic [7:0]   rx_mem [RX_DEPTH];
  logic [TX_AW:0] tx_wr_ptr, tx_rd_ptr, tx_count;
  logic [RX_AW:0] rx_wr_ptr, rx_rd_ptr, rx_count;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop, rx_capture;
  logic overrun, ovr_set, ovr_clr, flush, tx_active;
  logic bus_rd, bus_wr;
  logic [31:0] rd_mux;
  logic [15:0] baud_q;
  logic unused_bits;

  function automatic logic [3:0] sat4(input logic [31:0] v);
    return (v > 32'd15) ? 4'd15 : v[3:0];
  endfunction

  assign tx_count = tx_wr_ptr - tx_rd_ptr;
  assign rx_count = rx_wr_ptr - rx_rd_ptr;
  assign tx_empty = (tx_count == '0);
  assign rx_empty = (rx_count == '0);
  assign tx_full  = (tx_count == (TX_AW+1)'(TX_DEPTH));
  assign rx_full  = (rx_count == (RX_AW+1)'(RX_DEPTH));

  assign bus_rd  = req_valid & ~req_we;
  assign bus_wr  = req_valid & req_we;
  assign tx_push = bus_wr & (req_addr[3:2] == 2'd0) & ~tx_full;
  assign rx_pop  = bus_rd & (req_addr[3:2] == 2'd0) & ~rx_empty;
  assign flush   = bus_wr & (req_addr[3:2] == 2'd3) & req_wdata[1];
  assign ovr_clr = bus_wr & (req_addr[3:2] == 2'd3) & req_wdata[0];

  // Overflowing receive bytes are not stored; they only raise the sticky flag.
  assign rx_push = rx_capture & ~rx_full;
  assign ovr_set = rx_capture & rx_full;

  assign tx_active     = (tx_state != TX_IDLE);
  assign irq           = ~rx_empty | overrun;
  assign uart_baud_max = baud_q;
  assign unused_bits   = &{1'b0, req_addr[1:0], req_wdata[31:16]};

  // Register file read mux; empty DATA reads return zero.
  always_comb begin
    rd_mux = 32'd0;
    case (req_addr[3:2])
      2'd0: rd_mux = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rd_ptr[RX_AW-1:0]]};
      2'd1: rd_mux = {16'd0, sat4(32'(tx_count)), sat4(32'(rx_count)), 3'd0,
                      overrun, tx_active, tx_empty, tx_full, ~rx_empty};
      2'd2: rd_mux = {16'd0, baud_q};
      default: rd_mux = 32'd0;
    endcase
  end

  // Registered read response, one cycle after the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      resp_valid <= bus_rd;
      if (bus_rd) resp_rdata <= rd_mux;
    end
  end

  // Baud divisor and sticky overrun; a new overrun beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q  <= BAUD_RESET;
      overrun <= 1'b0;
    end else begin
      if (bus_wr && req_addr[3:2] == 2'd2) baud_q <= req_wdata[15:0];
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  // FIFO pointers; flush empties both FIFOs but leaves the frame in flight alone.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
    end
  end

  // FIFO storage, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[TX_AW-1:0]] <= req_wdata[7:0];
    if (rx_push) rx_mem[rx_wr_ptr[RX_AW-1:0]] <= uart_rx_data;
  end

  // FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      rx_state <= RX_WAIT;
    end else begin
      tx_state <= tx_state_n;
      rx_state <= rx_state_n;
    end
  end

  // TX next state: launch only from IDLE, so pulses are always separated.
  always_comb begin
    tx_state_n = tx_state;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE:  if (!tx_empty && !uart_busy) begin
                  tx_pop     = 1'b1;
                  tx_state_n = TX_START;
                end
      TX_START: if (uart_busy)  tx_state_n = TX_SEND;
      TX_SEND:  if (!uart_busy) tx_state_n = TX_IDLE;
      default:  tx_state_n = TX_IDLE;
    endcase
  end

  // RX next state: one capture per read_ready assertion.
  always_comb begin
    rx_state_n = rx_state;
    rx_capture = 1'b0;
    case (rx_state)
      RX_WAIT: if (uart_read_ready) begin
                 rx_capture = 1'b1;
                 rx_state_n = RX_ACK;
               end
      RX_ACK:  if (!uart_read_ready) rx_state_n = RX_WAIT;
      default: rx_state_n = RX_WAIT;
    endcase
  end

  // Core-facing outputs: single-cycle strobes, uart_data held between launches.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_we        <= 1'b0;
      uart_data      <= 8'hFF;
      uart_negate_rr <= 1'b0;
    end else begin
      uart_we        <= tx_pop;
      uart_negate_rr <= rx_capture;
      if (tx_pop) uart_data <= tx_mem[tx_rd_ptr[TX_AW-1:0]];
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboard bench for uart_mmio_ctrl with a simple behavioural UART core.
module tb_uart_mmio_ctrl;

  localparam int FRAME = 10;
  localparam logic [3:0] A_DATA = 4'h0, A_STAT = 4'h4, A_BAUD = 4'h8, A_CTRL = 4'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [3:0]  req_addr = 4'h0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid, irq, uart_we, uart_negate_rr;
  logic [31:0] resp_rdata;
  logic [7:0]  uart_data;
  logic [15:0] uart_baud_max;
  logic        uart_busy = 1'b0, uart_read_ready = 1'b0;
  logic [7:0]  uart_rx_data = 8'h00;

  int checks = 0, errors = 0;
  logic [31:0] exp_rd[$];
  string       exp_nm[$];
  logic [7:0]  exp_tx[$];
  int nrr_pulses = 0;
  bit stuck = 1'b0, in_frame = 1'b0, hold_bad = 1'b0;
  int busy_cnt = 0;
  logic [7:0] cur_byte = 8'h00;

  uart_mmio_ctrl #(.TX_DEPTH(8), .RX_DEPTH(8), .BAUD_RESET(16'd434)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .irq(irq),
    .uart_we(uart_we), .uart_data(uart_data), .uart_baud_max(uart_baud_max),
    .uart_negate_rr(uart_negate_rr), .uart_busy(uart_busy),
    .uart_read_ready(uart_read_ready), .uart_rx_data(uart_rx_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Behavioural core: busy for FRAME cycles after each write_enable; watches uart_data stability.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      in_frame = 1'b0;
    end else if (uart_we) begin
      busy_cnt = FRAME;
      cur_byte = uart_data;
      in_frame = 1'b1;
      hold_bad = 1'b0;
    end else if (busy_cnt > 0) begin
      if (uart_data !== cur_byte) hold_bad = 1'b1;
      busy_cnt--;
      if (busy_cnt == 0 && in_frame) begin
        check("tx_hold", 32'(hold_bad), 32'd0);
        in_frame = 1'b0;
      end
    end
    uart_busy = stuck || (busy_cnt != 0);
    if (uart_negate_rr) nrr_pulses++;
  end

  // Monitor: pops expected read data and transmitted bytes as the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected actual=0x%08h expected=none", resp_rdata);
        end else begin
          check(exp_nm.pop_front(), resp_rdata, exp_rd.pop_front());
        end
      end
      if (uart_we) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected actual=0x%02h expected=none", uart_data);
        end else begin
          check("tx_byte", {24'd0, uart_data}, {24'd0, exp_tx.pop_front()});
        end
      end
    end
  end

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
    exp_rd.push_back(exp);
    exp_nm.push_back(name);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input int hold);
    uart_rx_data = b;
    uart_read_ready = 1'b1;
    repeat (hold) @(negedge clk);
    uart_read_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_tx_drain(input int budget);
    int n = 0;
    while ((exp_tx.size() != 0 || uart_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("tx_drain_in_time", 32'(n < budget), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_uart_we", 32'(uart_we), 32'd0);
    check("rst_uart_data", 32'(uart_data), 32'hFF);
    check("rst_negate_rr", 32'(uart_negate_rr), 32'd0);
    check("rst_baud", 32'(uart_baud_max), 32'd434);
    bus_read(A_STAT, 32'h4, "status_reset");

    // Three bytes through a 10-cycle frame core
    exp_tx.push_back(8'h41); exp_tx.push_back(8'h42); exp_tx.push_back(8'h43);
    bus_write(A_DATA, 32'h41);
    bus_write(A_DATA, 32'h42);
    bus_write(A_DATA, 32'h43);
    wait_tx_drain(200);
    repeat (3) @(negedge clk);
    bus_read(A_STAT, 32'h4, "status_tx_done");

    // Fill the TX FIFO while the core is stuck busy; ninth byte must be dropped
    stuck = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) bus_write(A_DATA, 32'h60 + 32'(i));
    bus_read(A_STAT, 32'h8002, "status_tx_full");
    for (int i = 0; i < 8; i++) exp_tx.push_back(8'h60 + 8'(i));
    stuck = 1'b0;
    wait_tx_drain(400);
    repeat (3) @(negedge clk);
    bus_read(A_STAT, 32'h4, "status_tx_drained");

    // Single received byte held for 5 cycles
    nrr_pulses = 0;
    rx_frame(8'h5A, 5);
    check("nrr_single", 32'(nrr_pulses), 32'd1);
    check("irq_rx_pending", 32'(irq), 32'd1);
    bus_read(A_STAT, 32'h105, "status_rx_one");
    bus_read(A_DATA, 32'h5A, "rx_data_5a");
    check("irq_after_pop", 32'(irq), 32'd0);

    // Overrun: nine bytes into an 8-deep RX FIFO
    nrr_pulses = 0;
    for (int i = 0; i < 9; i++) rx_frame(8'h10 + 8'(i), 2);
    check("nrr_nine", 32'(nrr_pulses), 32'd9);
    check("irq_overrun", 32'(irq), 32'd1);
    bus_read(A_STAT, 32'h815, "status_overrun");
    bus_write(A_CTRL, 32'h1);
    bus_read(A_STAT, 32'h805, "status_ovr_cleared");
    for (int i = 0; i < 8; i++) bus_read(A_DATA, 32'h10 + 32'(i), "rx_data_fifo");
    check("irq_drained", 32'(irq), 32'd0);
    bus_read(A_STAT, 32'h4, "status_rx_drained");

    // Baud register
    bus_write(A_BAUD, 32'hABCD_0010);
    check("baud_out", 32'(uart_baud_max), 32'h10);
    bus_read(A_BAUD, 32'h10, "baud_readback");

    // Reset in the middle of a frame
    exp_tx.push_back(8'h77);
    bus_write(A_DATA, 32'h77);
    bus_write(A_DATA, 32'h78);
    repeat (5) @(negedge clk);
    check("busy_mid_frame", 32'(uart_busy), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_baud", 32'(uart_baud_max), 32'd434);
    check("midrst_uart_we", 32'(uart_we), 32'd0);
    check("midrst_uart_data", 32'(uart_data), 32'hFF);
    check("midrst_tx_queue", 32'(exp_tx.size()), 32'd0);
    bus_read(A_STAT, 32'h4, "status_after_rst");

    // Empty DATA read
    bus_read(A_DATA, 32'h0, "rx_empty_read");
    bus_read(A_STAT, 32'h4, "status_empty_read");

    // Flush with both FIFOs partly full; core stuck so nothing leaves TX
    stuck = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(A_DATA, 32'hA1);
    bus_write(A_DATA, 32'hA2);
    rx_frame(8'hB1, 2);
    rx_frame(8'hB2, 2);
    bus_read(A_STAT, 32'h2201, "status_pre_flush");
    bus_write(A_CTRL, 32'h2);
    bus_read(A_STAT, 32'h4, "status_flushed");
    check("irq_flushed", 32'(irq), 32'd0);
    stuck = 1'b0;
    repeat (30) @(negedge clk);

    check("end_tx_queue", 32'(exp_tx.size()), 32'd0);
    check("end_rd_queue", 32'(exp_rd.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
